// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a byte FIFO.
// Frame is start + 8 data bits (LSB first) + stop, idle-high, with (cfg_div_i+1) cycles per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_WIDTH-1:0]          cfg_div_i,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [7:0]           mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic [7:0]           shifter;
  logic [DIV_WIDTH-1:0] div_q, baud;
  logic [2:0]           bit_idx;
`ifdef UART_TX_PARITY_EN
  logic                 par;
`endif

  logic full, empty, push, pop, bit_end;

  // The extra pointer MSB tells a full FIFO apart from an empty one.
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty        = (wr_ptr == rd_ptr);
  assign tx_ready_o   = !full;
  assign push         = tx_valid_i && !full;
  assign bit_end      = (baud == div_q);
  // Pop when idle, or on the last stop cycle so back-to-back frames have no gap.
  assign pop          = !empty && ((state == IDLE) || (state == STOP && bit_end));
  assign fifo_count_o = wr_ptr - rd_ptr;
  assign busy_o       = (state != IDLE) || !empty;

  // FIFO storage write port (no reset needed, guarded by pointers).
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= tx_data_i;
  end

  // FIFO pointers; push and pop are independent so both can happen in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Frame sequencer with registered serial output; divisor is latched per frame at pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx_o    <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shifter <= '0;
      div_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx_o <= 1'b1;
          if (pop) begin
            shifter <= mem[rd_ptr[AW-1:0]];
`ifdef UART_TX_PARITY_EN
            par     <= ^mem[rd_ptr[AW-1:0]];
`endif
            div_q   <= cfg_div_i;
            baud    <= '0;
            state   <= START;
            tx_o    <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            baud    <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx_o    <= shifter[0];
            shifter <= {1'b0, shifter[7:1]};
          end else begin
            baud <= baud + DIV_WIDTH'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx_o  <= par;
`else
              state <= STOP;
              tx_o  <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_o    <= shifter[0];
              shifter <= {1'b0, shifter[7:1]};
            end
          end else begin
            baud <= baud + DIV_WIDTH'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud  <= '0;
            state <= STOP;
            tx_o  <= 1'b1;
          end else begin
            baud <= baud + DIV_WIDTH'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            baud <= '0;
            if (pop) begin
              shifter <= mem[rd_ptr[AW-1:0]];
`ifdef UART_TX_PARITY_EN
              par     <= ^mem[rd_ptr[AW-1:0]];
`endif
              div_q   <= cfg_div_i;
              state   <= START;
              tx_o    <= 1'b0;
            end else begin
              state <= IDLE;
              tx_o  <= 1'b1;
            end
          end else begin
            baud <= baud + DIV_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed tests plus a frame-level line model checked every cycle.
module tb_uart_tx_fifo;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cfg_div = '0;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, tx, busy;
  logic [3:0]  fifo_count;

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cfg_div_i(cfg_div), .tx_data_i(tx_data),
    .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_o(tx),
    .busy_o(busy), .fifo_count_o(fifo_count)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Model: queue of bytes and the frame currently on the line as a bit list in time order.
  byte unsigned  mq[$];
  bit            m_act = 1'b0;
  int            m_pos = 0, m_len = 1, m_bitlen = 1, pre = 0;
  logic [NB-1:0] m_frame = '1;

  function automatic logic [NB-1:0] mk_frame(input logic [7:0] b);
    logic [NB-1:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mq.delete();
      m_act = 1'b0;
      m_pos = 0;
      chk_en = 1'b1;
    end else begin
      pre = mq.size();
      if (m_act && m_pos < m_len - 1) m_pos++;
      else if (pre > 0) begin
        m_frame  = mk_frame(mq.pop_front());
        m_bitlen = int'(cfg_div) + 1;
        m_len    = NB * m_bitlen;
        m_pos    = 0;
        m_act    = 1'b1;
      end else m_act = 1'b0;
      if (tx_valid && pre < DEPTH) mq.push_back(tx_data);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_tx", 32'(tx), 32'(m_act ? m_frame[m_pos / m_bitlen] : 1'b1));
      chk("m_count", 32'(fifo_count), 32'(mq.size()));
      chk("m_ready", 32'(tx_ready), 32'(mq.size() < DEPTH));
      chk("m_busy", 32'(busy), 32'(m_act || mq.size() != 0));
    end
  end

  task automatic at(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 2000) begin
      at(cyc + 1);
      k++;
    end
    chk(nm, 32'(busy), 32'd0);
    chk({nm, "_cnt"}, 32'(fifo_count), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [0:7]  e1;
    logic [0:29] seq;
    e1  = 8'b10100110;
    seq = 30'b0000000001_0111111111_0101001011;

    // Reset state
    at(3);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    rst = 1'b0;
    at(6);

    // 1: div=31, byte 0x65
    cfg_div = 16'd31;
    n = cyc; tx_data = 8'h65; tx_valid = 1'b1;
    at(n + 1); tx_valid = 1'b0;
    at(n + 2);  chk("t1_start0", 32'(tx), 32'd0);
    at(n + 33); chk("t1_start31", 32'(tx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      at(n + 34 + 32 * i); chk("t1_bit", 32'(tx), 32'(e1[i]));
    end
    at(n + 290); chk("t1_stop", 32'(tx), 32'd1);
    at(n + 321); chk("t1_busy_last", 32'(busy), 32'd1);
    at(n + 322); chk("t1_busy_done", 32'(busy), 32'd0);
    at(n + 325);

    // 2: div=0, three bytes back-to-back, no idle gap
    cfg_div = 16'd0;
    n = cyc;
    tx_data = 8'h00; tx_valid = 1'b1;
    at(n + 1); tx_data = 8'hFF;
    at(n + 2); tx_data = 8'hA5;
    at(n + 3); tx_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      at(n + 2 + i); chk("t2_seq", 32'(tx), 32'(seq[i]));
    end
    at(n + 32); chk("t2_idle_tx", 32'(tx), 32'd1);
    chk("t2_idle_busy", 32'(busy), 32'd0);
    at(n + 35);

    // 3: div=3, fill FIFO while first frame runs, overflow push ignored
    cfg_div = 16'd3;
    n = cyc; tx_data = 8'h10; tx_valid = 1'b1;
    at(n + 1); tx_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      at(n + 3 + i); tx_data = 8'(8'h11 + i); tx_valid = 1'b1;
    end
    at(n + 11);
    chk("t3_full_cnt", 32'(fifo_count), 32'd8);
    chk("t3_full_ready", 32'(tx_ready), 32'd0);
    tx_data = 8'h99;
    at(n + 12); tx_valid = 1'b0;
    chk("t3_ignored_cnt", 32'(fifo_count), 32'd8);
    wait_idle("t3_idle");
    at(cyc + 3);

    // 4: div=7, reset during data bit 4
    cfg_div = 16'd7;
    n = cyc; tx_data = 8'hC3; tx_valid = 1'b1;
    at(n + 1); tx_data = 8'h11;
    at(n + 2); tx_valid = 1'b0;
    at(n + 42); chk("t4_bit4", 32'(tx), 32'd0);
    rst = 1'b1;
    at(n + 43); rst = 1'b0;
    chk("t4_tx", 32'(tx), 32'd1);
    chk("t4_cnt", 32'(fifo_count), 32'd0);
    chk("t4_ready", 32'(tx_ready), 32'd1);
    at(n + 143);
    chk("t4_quiet_tx", 32'(tx), 32'd1);
    chk("t4_quiet_busy", 32'(busy), 32'd0);

    // 5: divisor change mid-frame takes effect on the next frame
    n = cyc; tx_data = 8'h5A; tx_valid = 1'b1;
    at(n + 1);
    at(n + 2); tx_valid = 1'b0;
    at(n + 10); chk("t5_f1_b0", 32'(tx), 32'd0);
    cfg_div = 16'd1;
    at(n + 18); chk("t5_f1_b1a", 32'(tx), 32'd1);
    at(n + 25); chk("t5_f1_b1z", 32'(tx), 32'd1);
    at(n + 26); chk("t5_f1_b2", 32'(tx), 32'd0);
    at(n + 82); chk("t5_f2_st", 32'(tx), 32'd0);
    at(n + 84); chk("t5_f2_b0", 32'(tx), 32'd0);
    at(n + 86); chk("t5_f2_b1", 32'(tx), 32'd1);
    at(n + 88); chk("t5_f2_b2", 32'(tx), 32'd0);
    at(n + 90); chk("t5_f2_b3", 32'(tx), 32'd1);
    wait_idle("t5_idle");

`ifdef UART_TX_PARITY_EN
    // 6: parity bit, div=1
    cfg_div = 16'd1;
    at(cyc + 2);
    n = cyc; tx_data = 8'h07; tx_valid = 1'b1;
    at(n + 1); tx_valid = 1'b0;
    at(n + 18); chk("t6_b7", 32'(tx), 32'd0);
    at(n + 20); chk("t6_par1a", 32'(tx), 32'd1);
    at(n + 21); chk("t6_par1b", 32'(tx), 32'd1);
    at(n + 23); chk("t6_busy", 32'(busy), 32'd1);
    at(n + 24); chk("t6_done", 32'(busy), 32'd0);
    at(n + 26);
    n = cyc; tx_data = 8'h03; tx_valid = 1'b1;
    at(n + 1); tx_valid = 1'b0;
    at(n + 20); chk("t6_par0", 32'(tx), 32'd0);
    wait_idle("t6_idle");
`endif

    at(cyc + 4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
